// File: rtl/elevator_pkg.sv
// Shared constants for the elevator request scheduler: default sizing,
// scheduler state encodings and travel-direction values.
package elevator_pkg;

  localparam int DEF_N_FLOORS = 8;
  localparam int DEF_FLOOR_W  = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SELECT = 2'd1;
  localparam state_t ST_TRACK  = 2'd2;
  localparam state_t ST_SERVE  = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/elevator_target_picker.sv
// Combinational SCAN search: nearest pending floor in the travel direction,
// otherwise the nearest one behind the car with the direction reversed.
module elevator_target_picker
  import elevator_pkg::*;
#(
  parameter int N_FLOORS = DEF_N_FLOORS,
  parameter int FLOOR_W  = DEF_FLOOR_W
) (
  input  logic [N_FLOORS-1:0] i_pending,
  input  logic [FLOOR_W-1:0]  i_current,
  input  logic                i_dir,
  output logic                o_found,
  output logic [FLOOR_W-1:0]  o_floor,
  output logic                o_new_dir
);

  logic               w_ahead_found;
  logic               w_behind_found;
  logic [FLOOR_W-1:0] w_ahead;
  logic [FLOOR_W-1:0] w_behind;

  // Ascending scan: a "first hit" keeps the lowest floor, a "last hit" the highest.
  always_comb begin
    w_ahead_found  = 1'b0;
    w_behind_found = 1'b0;
    w_ahead        = '0;
    w_behind       = '0;
    for (int f = 0; f < N_FLOORS; f++) begin
      if (i_pending[f]) begin
        if (i_dir == DIR_UP) begin
          if (f >= int'(i_current) && !w_ahead_found) begin
            w_ahead_found = 1'b1;
            w_ahead       = FLOOR_W'(f);
          end
          if (f < int'(i_current)) begin
            w_behind_found = 1'b1;
            w_behind       = FLOOR_W'(f);
          end
        end else begin
          if (f <= int'(i_current)) begin
            w_ahead_found = 1'b1;
            w_ahead       = FLOOR_W'(f);
          end
          if (f > int'(i_current) && !w_behind_found) begin
            w_behind_found = 1'b1;
            w_behind       = FLOOR_W'(f);
          end
        end
      end
    end
  end

  assign o_found   = w_ahead_found | w_behind_found;
  assign o_floor   = w_ahead_found ? w_ahead : w_behind;
  assign o_new_dir = (w_ahead_found || !w_behind_found) ? i_dir : ~i_dir;

endmodule

// File: rtl/elevator_ctrl.sv
// Elevator request scheduler: collects floor calls, tracks car position and
// steers the elevator FSM toward the next SCAN target.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int N_FLOORS = DEF_N_FLOORS,
  parameter int FLOOR_W  = DEF_FLOOR_W
) (
  input  logic                i_ctrl_clock,
  input  logic                i_ctrl_reset,
  input  logic [N_FLOORS-1:0] i_ctrl_req,
  input  logic                i_ctrl_floor_tick,
  input  logic                i_fsm_move_up,
  input  logic                i_fsm_move_down,
  input  logic                i_fsm_fifo_rd_en,
  input  logic                i_fsm_alarm,
  output logic                o_ctrl_fsm_move_up,
  output logic                o_ctrl_fsm_move_down,
  output logic                o_ctrl_fsm_equal,
  output logic [FLOOR_W-1:0]  o_ctrl_target_floor,
  output logic [FLOOR_W-1:0]  o_ctrl_current_floor,
  output logic [N_FLOORS-1:0] o_ctrl_pending,
  output logic                o_ctrl_busy
);

  state_t              r_state;
  logic                r_dir;
  logic [FLOOR_W-1:0]  r_target;
  logic [FLOOR_W-1:0]  r_current;
  logic [N_FLOORS-1:0] r_pending;

  logic [N_FLOORS-1:0] w_cur_onehot;
  logic [N_FLOORS-1:0] w_clr;
  logic [N_FLOORS-1:0] w_pending_nxt;
  logic [N_FLOORS-1:0] w_pick_pending;
  logic                w_serve_done;
  logic                w_step_up;
  logic                w_step_down;
  logic                w_pick_found;
  logic [FLOOR_W-1:0]  w_pick_floor;
  logic                w_pick_dir;
  logic                w_retarget;
  logic                w_active;

  assign w_cur_onehot  = N_FLOORS'(1) << r_current;
  assign w_serve_done  = (r_state == ST_SERVE) && i_fsm_fifo_rd_en && !i_fsm_alarm;
  assign w_clr         = w_serve_done ? w_cur_onehot : '0;
  assign w_pending_nxt = (r_pending & ~w_clr) | i_ctrl_req;

  assign w_step_up   = i_ctrl_floor_tick && i_fsm_move_up && !i_fsm_move_down && !i_fsm_alarm;
  assign w_step_down = i_ctrl_floor_tick && i_fsm_move_down && !i_fsm_move_up && !i_fsm_alarm;

  // While tracking, the floor under the car is masked so the picker only reports floors strictly ahead.
  assign w_pick_pending = (r_state == ST_TRACK) ? (r_pending & ~w_cur_onehot) : r_pending;

  elevator_target_picker #(
    .N_FLOORS (N_FLOORS),
    .FLOOR_W  (FLOOR_W)
  ) u_picker (
    .i_pending (w_pick_pending),
    .i_current (r_current),
    .i_dir     (r_dir),
    .o_found   (w_pick_found),
    .o_floor   (w_pick_floor),
    .o_new_dir (w_pick_dir)
  );

  assign w_retarget = w_pick_found && (w_pick_dir == r_dir) &&
                      ((r_dir == DIR_UP) ? (w_pick_floor < r_target) : (w_pick_floor > r_target));

  always_ff @(posedge i_ctrl_clock or negedge i_ctrl_reset) begin
    if (!i_ctrl_reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  always_ff @(posedge i_ctrl_clock or negedge i_ctrl_reset) begin
    if (!i_ctrl_reset) begin
      r_current <= '0;
    end else if (w_step_up && r_current != FLOOR_W'(N_FLOORS - 1)) begin
      r_current <= r_current + FLOOR_W'(1);
    end else if (w_step_down && r_current != '0) begin
      r_current <= r_current - FLOOR_W'(1);
    end
  end

  // Alarm freezes the whole scheduler; only request capture and position tracking rules apply.
  always_ff @(posedge i_ctrl_clock or negedge i_ctrl_reset) begin
    if (!i_ctrl_reset) begin
      r_state  <= ST_IDLE;
      r_dir    <= DIR_UP;
      r_target <= '0;
    end else if (!i_fsm_alarm) begin
      case (r_state)
        ST_IDLE: begin
          if (r_pending != '0) r_state <= ST_SELECT;
        end
        ST_SELECT: begin
          if (w_pick_found) begin
            r_target <= w_pick_floor;
            r_dir    <= w_pick_dir;
            r_state  <= ST_TRACK;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_TRACK: begin
          if (r_target == r_current) r_state  <= ST_SERVE;
          else if (w_retarget)       r_target <= w_pick_floor;
        end
        default: begin
          if (w_serve_done) r_state <= (w_pending_nxt != '0) ? ST_SELECT : ST_IDLE;
        end
      endcase
    end
  end

  assign w_active             = (r_state == ST_TRACK) || (r_state == ST_SERVE);
  assign o_ctrl_fsm_move_up   = w_active && (r_target > r_current);
  assign o_ctrl_fsm_move_down = w_active && (r_target < r_current);
  assign o_ctrl_fsm_equal     = w_active && (r_target == r_current);
  assign o_ctrl_target_floor  = r_target;
  assign o_ctrl_current_floor = r_current;
  assign o_ctrl_pending       = r_pending;
  assign o_ctrl_busy          = (r_state != ST_IDLE);

endmodule
